arp_tx_ctrl: RTL and testbench

- Scheduler and handshake sequencer in front of the ARP frame transmitter (arp_send).
- Arbitrates three ARP sources: reply requests from the RX parser, address-resolution queries from the host, and periodic gratuitous announces from an internal timer.
- Builds the ARP field set for the winner and drives the transmitter's enable/ready handshake.
- Recovers from a transmitter that never accepts a frame.

---
 rtl/arp_pkg.sv | 25 ++
 rtl/arp_tx_ctrl_timer.sv | 38 +++
 rtl/arp_tx_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_arp_tx_ctrl.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arp_pkg.sv
// Shared ARP constants, frame kinds and controller states
// for the ARP transmit scheduler.
package arp_pkg;

  localparam logic [1:0]  ARP_OP_REQUEST = 2'd1;
  localparam logic [1:0]  ARP_OP_REPLY   = 2'd2;
  localparam logic [47:0] MAC_BCAST      = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    KIND_NONE     = 2'd0,
    KIND_REPLY    = 2'd1,
    KIND_QUERY    = 2'd2,
    KIND_ANNOUNCE = 2'd3
  } kind_e;

  typedef enum logic [2:0] {
    ST_WAIT_RDY,
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_RELEASE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/arp_tx_ctrl_timer.sv
// Gratuitous-announce period counter with a coalescing
// pending flag; hold keeps state while an announce is in flight.
module arp_announce_timer #(
  parameter int PERIOD = 125000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic hold,
  input  logic clr,
  output logic pending
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else if (en) begin
      if (cnt == W'(PERIOD - 1)) begin
        cnt     <= '0;
        pending <= 1'b1;
      end else begin
        cnt <= cnt + W'(1);
        if (clr) pending <= 1'b0;
      end
    end else if (!hold) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else if (clr) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/arp_tx_ctrl.sv
// ARP transmit scheduler: arbitrates reply/query/announce
// sources and sequences the transmitter enable/ready handshake.
module arp_tx_ctrl
  import arp_pkg::*;
#(
  parameter int ANNOUNCE_PERIOD = 125000000,
  parameter int HS_TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] i_local_mac,
  input  logic [31:0] i_local_ip,
  input  logic        i_announce_en,
  input  logic        i_rpl_req,
  input  logic [47:0] i_rpl_mac,
  input  logic [31:0] i_rpl_ip,
  input  logic        i_qry_req,
  input  logic [31:0] i_qry_ip,
  output logic [47:0] o_dst_mac,
  output logic [47:0] o_src_mac,
  output logic [47:0] o_SHA,
  output logic [47:0] o_THA,
  output logic [31:0] o_SPA,
  output logic [31:0] o_TPA,
  output logic [1:0]  o_operation,
  output logic        o_enable,
  input  logic        i_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_kind,
  output logic        o_err,
  output logic        o_rpl_drop,
  output logic        o_qry_drop
);

  localparam int TW = (HS_TIMEOUT > 1) ? $clog2(HS_TIMEOUT) : 1;

  state_e        state;
  kind_e         cur;
  logic [TW-1:0] to_cnt;

  logic        rpl_vld, qry_vld;
  logic [47:0] rpl_mac;
  logic [31:0] rpl_ip, qry_ip;

  logic ann_pend, ann_hold, ann_clr;
  logic rpl_free, qry_free, in_frame;

  assign in_frame = state inside {ST_LOAD, ST_REQ, ST_RELEASE, ST_DONE};
  assign ann_hold = in_frame && (cur == KIND_ANNOUNCE);
  assign ann_clr  = (state == ST_DONE) && (cur == KIND_ANNOUNCE);
  assign rpl_free = (state == ST_DONE) && (cur == KIND_REPLY);
  assign qry_free = (state == ST_DONE) && (cur == KIND_QUERY);

  arp_announce_timer #(
    .PERIOD(ANNOUNCE_PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (i_announce_en),
    .hold   (ann_hold),
    .clr    (ann_clr),
    .pending(ann_pend)
  );

  // A slot being freed in DONE can take a new pulse in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpl_vld    <= 1'b0;
      qry_vld    <= 1'b0;
      rpl_mac    <= '0;
      rpl_ip     <= '0;
      qry_ip     <= '0;
      o_rpl_drop <= 1'b0;
      o_qry_drop <= 1'b0;
    end else begin
      o_rpl_drop <= 1'b0;
      o_qry_drop <= 1'b0;
      if (i_rpl_req && (!rpl_vld || rpl_free)) begin
        rpl_vld <= 1'b1;
        rpl_mac <= i_rpl_mac;
        rpl_ip  <= i_rpl_ip;
      end else begin
        if (rpl_free)  rpl_vld    <= 1'b0;
        if (i_rpl_req) o_rpl_drop <= 1'b1;
      end
      if (i_qry_req && (!qry_vld || qry_free)) begin
        qry_vld <= 1'b1;
        qry_ip  <= i_qry_ip;
      end else begin
        if (qry_free)  qry_vld    <= 1'b0;
        if (i_qry_req) o_qry_drop <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_WAIT_RDY;
      cur         <= KIND_NONE;
      to_cnt      <= '0;
      o_enable    <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_kind      <= '0;
      o_operation <= '0;
      o_dst_mac   <= '0;
      o_src_mac   <= '0;
      o_SHA       <= '0;
      o_THA       <= '0;
      o_SPA       <= '0;
      o_TPA       <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      unique case (state)
        ST_WAIT_RDY: begin
          o_enable <= 1'b0;
          if (i_ready) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (rpl_vld || qry_vld || ann_pend) begin
            if (rpl_vld)      cur <= KIND_REPLY;
            else if (qry_vld) cur <= KIND_QUERY;
            else              cur <= KIND_ANNOUNCE;
            o_busy <= 1'b1;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          o_src_mac <= i_local_mac;
          o_SHA     <= i_local_mac;
          o_SPA     <= i_local_ip;
          unique case (cur)
            KIND_REPLY: begin
              o_operation <= ARP_OP_REPLY;
              o_dst_mac   <= rpl_mac;
              o_THA       <= rpl_mac;
              o_TPA       <= rpl_ip;
            end
            KIND_QUERY: begin
              o_operation <= ARP_OP_REQUEST;
              o_dst_mac   <= MAC_BCAST;
              o_THA       <= '0;
              o_TPA       <= qry_ip;
            end
            default: begin
              o_operation <= ARP_OP_REQUEST;
              o_dst_mac   <= MAC_BCAST;
              o_THA       <= '0;
              o_TPA       <= i_local_ip;
            end
          endcase
          o_enable <= 1'b1;
          to_cnt   <= '0;
          state    <= ST_REQ;
        end
        ST_REQ: begin
          if (!i_ready) begin
            o_enable <= 1'b0;
            state    <= ST_RELEASE;
          end else if (to_cnt == TW'(HS_TIMEOUT - 1)) begin
            // Abort leaves the source pending so it is retried.
            o_enable <= 1'b0;
            o_err    <= 1'b1;
            o_busy   <= 1'b0;
            state    <= ST_WAIT_RDY;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        ST_RELEASE: begin
          if (i_ready) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            o_kind <= cur;
            state  <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_WAIT_RDY;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_tx_ctrl.sv
// Scoreboard bench for arp_tx_ctrl with a behavioural
// transmitter model driving i_ready.
module tb_arp_tx_ctrl;

  localparam int PER = 16;
  localparam int HST = 8;
  localparam logic [47:0] LMAC = 48'h02AA_BBCC_DDEE;
  localparam logic [31:0] LIP  = 32'h0A00_0001;
  localparam logic [47:0] BC   = 48'hFFFF_FFFF_FFFF;

  logic        clk, rst_n;
  logic [47:0] i_local_mac, i_rpl_mac;
  logic [31:0] i_local_ip, i_rpl_ip, i_qry_ip;
  logic        i_announce_en, i_rpl_req, i_qry_req, i_ready;
  logic [47:0] o_dst_mac, o_src_mac, o_SHA, o_THA;
  logic [31:0] o_SPA, o_TPA;
  logic [1:0]  o_operation, o_kind;
  logic        o_enable, o_busy, o_done, o_err;
  logic        o_rpl_drop, o_qry_drop;

  arp_tx_ctrl #(
    .ANNOUNCE_PERIOD(PER),
    .HS_TIMEOUT     (HST)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_local_mac  (i_local_mac),
    .i_local_ip   (i_local_ip),
    .i_announce_en(i_announce_en),
    .i_rpl_req    (i_rpl_req),
    .i_rpl_mac    (i_rpl_mac),
    .i_rpl_ip     (i_rpl_ip),
    .i_qry_req    (i_qry_req),
    .i_qry_ip     (i_qry_ip),
    .o_dst_mac    (o_dst_mac),
    .o_src_mac    (o_src_mac),
    .o_SHA        (o_SHA),
    .o_THA        (o_THA),
    .o_SPA        (o_SPA),
    .o_TPA        (o_TPA),
    .o_operation  (o_operation),
    .o_enable     (o_enable),
    .i_ready      (i_ready),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_kind       (o_kind),
    .o_err        (o_err),
    .o_rpl_drop   (o_rpl_drop),
    .o_qry_drop   (o_qry_drop)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  op;
    logic [47:0] dst;
    logic [47:0] src;
    logic [47:0] sha;
    logic [47:0] tha;
    logic [31:0] spa;
    logic [31:0] tpa;
  } frame_t;

  frame_t exp_q[$];
  frame_t act_q[$];
  int     done_cyc[$];
  int     act_rd = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     qdrop_cnt = 0;
  int     rdrop_cnt = 0;
  int     err_cnt = 0;
  int     en_cycles = 0;
  bit     hold_low = 1'b1;
  bit     stuck = 1'b0;
  int     busy_cnt = 0;
  frame_t mon_f;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter: drops ready one cycle into a request, raises it 3 later.
  initial begin
    i_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_low) begin
        i_ready  = 1'b0;
        busy_cnt = 0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) i_ready = 1'b1;
      end else if (!stuck && o_enable && i_ready) begin
        i_ready  = 1'b0;
        busy_cnt = 3;
      end else begin
        i_ready = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (o_enable)   en_cycles++;
      if (o_qry_drop) qdrop_cnt++;
      if (o_rpl_drop) rdrop_cnt++;
      if (o_err)      err_cnt++;
      if (o_done) begin
        mon_f.kind = o_kind;
        mon_f.op   = o_operation;
        mon_f.dst  = o_dst_mac;
        mon_f.src  = o_src_mac;
        mon_f.sha  = o_SHA;
        mon_f.tha  = o_THA;
        mon_f.spa  = o_SPA;
        mon_f.tpa  = o_TPA;
        act_q.push_back(mon_f);
        done_cyc.push_back(cyc);
      end
    end
  end

  function automatic frame_t mk(input logic [1:0] k,
                                input logic [47:0] mac,
                                input logic [31:0] ip);
    frame_t f;
    f.kind = k;
    f.src  = LMAC;
    f.sha  = LMAC;
    f.spa  = LIP;
    case (k)
      2'd1: begin
        f.op = 2'd2; f.dst = mac; f.tha = mac; f.tpa = ip;
      end
      2'd2: begin
        f.op = 2'd1; f.dst = BC; f.tha = '0; f.tpa = ip;
      end
      default: begin
        f.op = 2'd1; f.dst = BC; f.tha = '0; f.tpa = LIP;
      end
    endcase
    return f;
  endfunction

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while ((act_q.size() - act_rd) < n && t < 400) begin
      @(posedge clk);
      t++;
    end
  endtask

  task automatic pulse_rpl(input logic [47:0] m, input logic [31:0] ip);
    @(posedge clk); #1;
    i_rpl_req = 1'b1; i_rpl_mac = m; i_rpl_ip = ip;
    @(posedge clk); #1;
    i_rpl_req = 1'b0;
  endtask

  task automatic test_reset;
    logic [265:0] outs;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outs = {o_dst_mac, o_src_mac, o_SHA, o_THA, o_SPA, o_TPA,
            o_operation, o_enable, o_busy, o_done, o_kind,
            o_err, o_rpl_drop, o_qry_drop};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (o_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_rdy_enable: got %b want 0", o_enable);
      end
    end
    hold_low = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (en_cycles != 0 || act_q.size() != 0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_frame: en=%0d frames=%0d busy=%b want 0 0 0",
               en_cycles, act_q.size(), o_busy);
    end
  endtask

  task automatic test_reply;
    frame_t e, a;
    e = mk(2'd1, 48'h0011_2233_4455, 32'hC0A8_0007);
    exp_q.push_back(e);
    @(posedge clk); #1;
    i_rpl_req = 1'b1; i_rpl_mac = 48'h0011_2233_4455; i_rpl_ip = 32'hC0A8_0007;
    @(posedge clk); #1;
    i_rpl_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (o_enable !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reply_load: enable=%b busy=%b want 0 1", o_enable, o_busy);
    end
    @(negedge clk);
    n_checks++;
    if (o_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL reply_enable: got %b want 1", o_enable);
    end
    n_checks++;
    if ({o_operation, o_dst_mac, o_THA, o_TPA} !== {e.op, e.dst, e.tha, e.tpa}) begin
      n_fail++;
      $display("FAIL reply_fields: got %h %h %h %h want %h %h %h %h",
               o_operation, o_dst_mac, o_THA, o_TPA, e.op, e.dst, e.tha, e.tpa);
    end
    wait_frames(1);
    n_checks++;
    if ((act_q.size() - act_rd) < 1) begin
      n_fail++;
      $display("FAIL reply_timeout: got %0d frames want 1", act_q.size() - act_rd);
    end else begin
      a = act_q[act_rd]; act_rd++;
      e = exp_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL reply_frame: got %h want %h", a, e);
      end
    end
  endtask

  task automatic test_priority;
    frame_t e, a;
    @(posedge clk); #1;
    rst_n = 1'b0; hold_low = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back(mk(2'd1, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0101));
    exp_q.push_back(mk(2'd2, '0, 32'hC0A8_0202));
    exp_q.push_back(mk(2'd3, '0, '0));
    @(posedge clk); #1;
    i_rpl_req = 1'b1; i_rpl_mac = 48'h0A0B_0C0D_0E0F; i_rpl_ip = 32'hC0A8_0101;
    i_qry_req = 1'b1; i_qry_ip = 32'hC0A8_0202;
    i_announce_en = 1'b1;
    @(posedge clk); #1;
    i_rpl_req = 1'b0; i_qry_req = 1'b0;
    repeat (18) @(posedge clk);
    #1 hold_low = 1'b0;
    wait_frames(3);
    #1 i_announce_en = 1'b0;
    repeat (30) @(posedge clk);
    n_checks++;
    if ((act_q.size() - act_rd) != 3) begin
      n_fail++;
      $display("FAIL prio_count: got %0d frames want 3", act_q.size() - act_rd);
    end
    while ((act_q.size() - act_rd) > 0 && exp_q.size() > 0) begin
      a = act_q[act_rd]; act_rd++;
      e = exp_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL prio_frame: got %h want %h", a, e);
      end
    end
    exp_q.delete();
    act_rd = act_q.size();
  endtask

  task automatic test_drop;
    frame_t e, a;
    int d0, t;
    d0 = qdrop_cnt;
    exp_q.push_back(mk(2'd2, '0, 32'hC0A8_0010));
    @(posedge clk); #1;
    i_qry_req = 1'b1; i_qry_ip = 32'hC0A8_0010;
    @(posedge clk); #1;
    i_qry_ip = 32'hC0A8_0020;
    @(posedge clk); #1;
    i_qry_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_qry_drop !== 1'b1) begin
      n_fail++;
      $display("FAIL qry_drop_pulse: got %b want 1", o_qry_drop);
    end
    t = 0;
    while (!o_done && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (!o_done) begin
      n_fail++;
      $display("FAIL drop_done_timeout: got o_done=%b want 1", o_done);
    end else begin
      exp_q.push_back(mk(2'd2, '0, 32'hC0A8_0030));
      i_qry_req = 1'b1; i_qry_ip = 32'hC0A8_0030;
      @(posedge clk); #1;
      i_qry_req = 1'b0;
    end
    wait_frames(2);
    n_checks++;
    if ((act_q.size() - act_rd) != 2) begin
      n_fail++;
      $display("FAIL drop_count: got %0d frames want 2", act_q.size() - act_rd);
    end
    while ((act_q.size() - act_rd) > 0 && exp_q.size() > 0) begin
      a = act_q[act_rd]; act_rd++;
      e = exp_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL drop_frame: got %h want %h", a, e);
      end
    end
    n_checks++;
    if (qdrop_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL qry_drop_count: got %0d want 1", qdrop_cnt - d0);
    end
  endtask

  task automatic test_announce;
    frame_t e, a;
    int base;
    base = done_cyc.size();
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(2'd3, '0, '0));
    @(posedge clk); #1;
    i_announce_en = 1'b1;
    wait_frames(3);
    #1 i_announce_en = 1'b0;
    n_checks++;
    if ((act_q.size() - act_rd) < 3) begin
      n_fail++;
      $display("FAIL ann_timeout: got %0d frames want 3", act_q.size() - act_rd);
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (done_cyc[base+i] - done_cyc[base+i-1] != PER) begin
          n_fail++;
          $display("FAIL ann_period: got %0d want %0d",
                   done_cyc[base+i] - done_cyc[base+i-1], PER);
        end
      end
    end
    while ((act_q.size() - act_rd) > 0 && exp_q.size() > 0) begin
      a = act_q[act_rd]; act_rd++;
      e = exp_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL ann_frame: got %h want %h", a, e);
      end
    end
    repeat (40) @(posedge clk);
    n_checks++;
    if ((act_q.size() - act_rd) != 0) begin
      n_fail++;
      $display("FAIL ann_disabled: got %0d extra frames want 0", act_q.size() - act_rd);
    end
  endtask

  task automatic test_timeout;
    frame_t e, a;
    int e0, en0, t;
    e0 = err_cnt;
    en0 = en_cycles;
    stuck = 1'b1;
    exp_q.push_back(mk(2'd1, 48'h0066_7788_99AA, 32'hC0A8_0909));
    pulse_rpl(48'h0066_7788_99AA, 32'hC0A8_0909);
    t = 0;
    while (!o_err && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (o_err !== 1'b1 || o_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_abort: err=%b enable=%b want 1 0", o_err, o_enable);
    end
    n_checks++;
    if (en_cycles - en0 != HST) begin
      n_fail++;
      $display("FAIL hs_req_cycles: got %0d want %0d", en_cycles - en0, HST);
    end
    stuck = 1'b0;
    wait_frames(1);
    n_checks++;
    if ((act_q.size() - act_rd) < 1) begin
      n_fail++;
      $display("FAIL retry_timeout: got %0d frames want 1", act_q.size() - act_rd);
    end else begin
      a = act_q[act_rd]; act_rd++;
      e = exp_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL retry_frame: got %h want %h", a, e);
      end
    end
    n_checks++;
    if (err_cnt - e0 != 1 || rdrop_cnt != 0) begin
      n_fail++;
      $display("FAIL err_count: got err=%0d rdrop=%0d want 1 0",
               err_cnt - e0, rdrop_cnt);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    i_local_mac   = LMAC;
    i_local_ip    = LIP;
    i_announce_en = 1'b0;
    i_rpl_req     = 1'b0;
    i_rpl_mac     = '0;
    i_rpl_ip      = '0;
    i_qry_req     = 1'b0;
    i_qry_ip      = '0;
    test_reset();
    test_reply();
    test_priority();
    test_drop();
    test_announce();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
